// File: rtl/tdp_bist_pkg.sv
// rtl/tdp_bist_pkg.sv - shared state encoding and data pattern for the TDP BRAM BIST
package tdp_bist_pkg;

  localparam int MAX_ABITS = 32;
  localparam int MAX_DBITS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_XREAD,
    ST_INV,
    ST_SREAD,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  // Address bits tiled LSB-first across the data word, then scrambled by the seed.
  function automatic logic [MAX_DBITS-1:0] pat_d(
    input logic [MAX_ABITS-1:0] x,
    input int                   abits,
    input int                   dbits,
    input logic [MAX_DBITS-1:0] seed
  );
    logic [MAX_DBITS-1:0] r;
    logic [4:0]           idx;
    r = '0;
    for (int i = 0; i < MAX_DBITS; i++) begin
      idx = 5'(i % abits);
      if (i < dbits) r[i] = x[idx];
    end
    return r ^ seed;
  endfunction

endpackage

// File: rtl/tdp_bist_chk.sv
// rtl/tdp_bist_chk.sv - one-stage read-compare pipeline shared by both ports with first-fail capture
module tdp_bist_chk
  import tdp_bist_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 18
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_rd_en,
  input  logic [ABITS-1:0] i_addr_a,
  input  logic [ABITS-1:0] i_addr_b,
  input  logic [DBITS-1:0] i_exp_a,
  input  logic [DBITS-1:0] i_exp_b,
  input  logic [DBITS-1:0] i_rd_a,
  input  logic [DBITS-1:0] i_rd_b,
  output logic             o_mismatch,
  output logic             o_fail,
  output logic [ABITS-1:0] o_fail_addr,
  output logic             o_fail_port
);

  logic             r_vld;
  logic [DBITS-1:0] r_exp_a;
  logic [DBITS-1:0] r_exp_b;
  logic [ABITS-1:0] r_addr_a;
  logic [ABITS-1:0] r_addr_b;
  logic             r_fail;
  logic [ABITS-1:0] r_fail_addr;
  logic             r_fail_port;

  logic w_mis_a;
  logic w_mis_b;

  assign w_mis_a    = r_vld && (i_rd_a != r_exp_a);
  assign w_mis_b    = r_vld && (i_rd_b != r_exp_b);
  assign o_mismatch = w_mis_a || w_mis_b;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_vld       <= 1'b0;
      r_exp_a     <= '0;
      r_exp_b     <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_port <= 1'b0;
    end else begin
      r_vld    <= i_rd_en && !i_clr;
      r_exp_a  <= i_exp_a;
      r_exp_b  <= i_exp_b;
      r_addr_a <= i_addr_a;
      r_addr_b <= i_addr_b;
      if (i_clr) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_port <= 1'b0;
      end else if ((w_mis_a || w_mis_b) && !r_fail) begin
        // Port A wins a simultaneous mismatch; only the first event is kept.
        r_fail      <= 1'b1;
        r_fail_addr <= w_mis_a ? r_addr_a : r_addr_b;
        r_fail_port <= !w_mis_a;
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_port = r_fail_port;

endmodule

// File: rtl/tdp_bram_bist.sv
// rtl/tdp_bram_bist.sv - split-half march BIST driving both ports of a true dual-port BRAM
module tdp_bram_bist #(
  parameter int               ABITS = 10,
  parameter int               DBITS = 18,
  parameter logic [DBITS-1:0] SEED  = {DBITS{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [ABITS-1:0] fail_addr,
  output logic             fail_port,
  output logic [ABITS-1:0] a_a,
  output logic [DBITS-1:0] wd_a,
  output logic             we_a,
  input  logic [DBITS-1:0] rd_a,
  output logic [ABITS-1:0] a_b,
  output logic [DBITS-1:0] wd_b,
  output logic             we_b,
  input  logic [DBITS-1:0] rd_b
);
  import tdp_bist_pkg::*;

  localparam int              KBITS  = ABITS - 1;
  localparam logic [KBITS-1:0] K_LAST = '1;

  bist_state_t      r_state;
  bist_state_t      w_state_nxt;
  logic [KBITS-1:0] r_k;

  logic             w_last;
  logic             w_start_ok;
  logic             w_counting;
  logic             w_mismatch;
  logic [ABITS-1:0] w_lo;
  logic [ABITS-1:0] w_hi;
  logic [DBITS-1:0] w_d_lo;
  logic [DBITS-1:0] w_d_hi;
  logic             w_rd_en;
  logic [DBITS-1:0] w_exp_a;
  logic [DBITS-1:0] w_exp_b;

  function automatic logic [DBITS-1:0] d_of(input logic [ABITS-1:0] x);
    return DBITS'(pat_d(MAX_ABITS'(x), ABITS, DBITS, MAX_DBITS'(SEED)));
  endfunction

  // Port A always owns the lower half and port B the upper half (or swapped
  // for cross reads), so the two ports can never collide on an address.
  assign w_lo       = {1'b0, r_k};
  assign w_hi       = {1'b1, r_k};
  assign w_d_lo     = d_of(w_lo);
  assign w_d_hi     = d_of(w_hi);
  assign w_last     = (r_k == K_LAST);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_counting = (r_state == ST_FILL) || (r_state == ST_XREAD) ||
                      (r_state == ST_INV)  || (r_state == ST_SREAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_counting && (w_state_nxt == r_state)) r_k <= r_k + 1'b1;
      else                                        r_k <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_FILL;
      ST_FILL:          if (w_last) w_state_nxt = ST_XREAD;
      ST_XREAD: begin
        if (w_mismatch)  w_state_nxt = ST_DONE;
        else if (w_last) w_state_nxt = ST_INV;
      end
      ST_INV: begin
        if (w_mismatch)  w_state_nxt = ST_DONE;
        else if (w_last) w_state_nxt = ST_SREAD;
      end
      ST_SREAD: begin
        if (w_mismatch)  w_state_nxt = ST_DONE;
        else if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    a_a     = '0;
    a_b     = '0;
    wd_a    = '0;
    wd_b    = '0;
    w_rd_en = 1'b0;
    w_exp_a = '0;
    w_exp_b = '0;
    case (r_state)
      ST_FILL: begin
        busy = 1'b1;
        we_a = 1'b1;
        a_a  = w_lo;
        wd_a = w_d_lo;
        we_b = 1'b1;
        a_b  = w_hi;
        wd_b = ~w_d_hi;
      end
      ST_XREAD: begin
        busy    = 1'b1;
        w_rd_en = 1'b1;
        a_a     = w_hi;
        w_exp_a = ~w_d_hi;
        a_b     = w_lo;
        w_exp_b = w_d_lo;
      end
      ST_INV: begin
        busy = 1'b1;
        we_a = 1'b1;
        a_a  = w_lo;
        wd_a = ~w_d_lo;
        we_b = 1'b1;
        a_b  = w_hi;
        wd_b = w_d_hi;
      end
      ST_SREAD: begin
        busy    = 1'b1;
        w_rd_en = 1'b1;
        a_a     = w_lo;
        w_exp_a = ~w_d_lo;
        a_b     = w_hi;
        w_exp_b = w_d_hi;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  tdp_bist_chk #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_chk (
    .clk         (clk),
    .i_rst       (rst),
    .i_clr       (w_start_ok),
    .i_rd_en     (w_rd_en),
    .i_addr_a    (a_a),
    .i_addr_b    (a_b),
    .i_exp_a     (w_exp_a),
    .i_exp_b     (w_exp_b),
    .i_rd_a      (rd_a),
    .i_rd_b      (rd_b),
    .o_mismatch  (w_mismatch),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_fail_port (fail_port)
  );

endmodule

// File: tb/tb_tdp_bram_bist.sv
// tb/tb_tdp_bram_bist.sv - directed bench for tdp_bram_bist with behavioural 1-cycle TDP RAMs
module tb_tdp_bram_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;

  logic       busy, done, fail, fail_port, we_a, we_b;
  logic [3:0] fail_addr, a_a, a_b;
  logic [7:0] wd_a, wd_b, rd_a, rd_b;

  logic       busy2, done2, fail2, fail_port2, we_a2, we_b2;
  logic [1:0] fail_addr2, a_a2, a_b2;
  logic [7:0] wd_a2, wd_b2, rd_a2, rd_b2;

  int checks = 0;
  int errors = 0;
  int coll   = 0;

  logic       inj_a = 1'b0;
  logic       inj_b = 1'b0;
  logic [3:0] inj_b_addr = 4'd0;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [4];

  tdp_bram_bist #(.ABITS(4), .DBITS(8), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_port(fail_port),
    .a_a(a_a), .wd_a(wd_a), .we_a(we_a), .rd_a(rd_a),
    .a_b(a_b), .wd_b(wd_b), .we_b(we_b), .rd_b(rd_b)
  );

  tdp_bram_bist #(.ABITS(2), .DBITS(8), .SEED(8'hA5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .fail(fail2),
    .fail_addr(fail_addr2), .fail_port(fail_port2),
    .a_a(a_a2), .wd_a(wd_a2), .we_a(we_a2), .rd_a(rd_a2),
    .a_b(a_b2), .wd_b(wd_b2), .we_b(we_b2), .rd_b(rd_b2)
  );

  // Ideal RAMs with optional read corruption at chosen addresses.
  always @(posedge clk) begin
    if (we_a) mem1[a_a] <= wd_a;
    if (we_b) mem1[a_b] <= wd_b;
    rd_a <= (inj_a && !we_a && a_a == 4'd2) ? (mem1[a_a] ^ 8'h01) : mem1[a_a];
    rd_b <= (inj_b && !we_b && a_b == inj_b_addr) ? (mem1[a_b] ^ 8'h01) : mem1[a_b];
    if (we_a2) mem2[a_a2] <= wd_a2;
    if (we_b2) mem2[a_b2] <= wd_b2;
    rd_a2 <= mem2[a_a2];
    rd_b2 <= mem2[a_b2];
  end

  always @(negedge clk) begin
    if ((we_a || we_b) && a_a == a_b) coll++;
    if ((we_a2 || we_b2) && a_a2 == a_b2) coll++;
  end

  function automatic logic [7:0] d4(input logic [3:0] x);
    return {x, x} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] d2(input logic [1:0] x);
    return {x, x, x, x} ^ 8'hA5;
  endfunction

  // Called at a negedge; cycle 0 is the cycle in which start is first sampled.
  task automatic run(input int sel, input int pulse_cyc,
                     output int fb, output int lb, output int nb, output int dc);
    int cyc;
    fb = -1; lb = -1; nb = 0; dc = -1; cyc = 0;
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    while (dc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
      cyc++;
      if (cyc == pulse_cyc) start = 1'b1;
      @(negedge clk);
      if ((sel == 0) ? busy : busy2) begin
        if (fb < 0) fb = cyc;
        lb = cyc;
        nb++;
      end
      if ((sel == 0) ? done : done2) dc = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_addr, fail_port, we_a, we_b, a_a, a_b, wd_a, wd_b} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, fail, fail_addr, fail_port, we_a, we_b, a_a, a_b, wd_a, wd_b});
    end
    checks++;
    if ({busy2, done2, fail2, fail_addr2, fail_port2, we_a2, we_b2, a_a2, a_b2, wd_a2, wd_b2} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs2: got %h expected 0",
               {busy2, done2, fail2, fail_addr2, fail_port2, we_a2, we_b2, a_a2, a_b2, wd_a2, wd_b2});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, we_a, we_b} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, we_a, we_b});
    end
  endtask

  task automatic test_pass();
    int fb, lb, nb, dc;
    run(0, -1, fb, lb, nb, dc);
    checks++;
    if (fb !== 1 || lb !== 33 || nb !== 33) begin
      errors++;
      $display("FAIL pass_busy_window: got first=%0d last=%0d count=%0d expected 1 33 33", fb, lb, nb);
    end
    checks++;
    if (dc !== 34 || fail !== 1'b0) begin
      errors++;
      $display("FAIL pass_done: got done_cycle=%0d fail=%b expected 34 0", dc, fail);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_v;
      exp_v = (i < 8) ? ~d4(4'(i)) : d4(4'(i));
      checks++;
      if (mem1[i] !== exp_v) begin
        errors++;
        $display("FAIL pass_mem[%0d]: got %h expected %h", i, mem1[i], exp_v);
      end
    end
  endtask

  task automatic test_start_ignored();
    int fb, lb, nb, dc;
    run(0, 10, fb, lb, nb, dc);
    checks++;
    if (lb !== 33 || nb !== 33 || dc !== 34 || fail !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy: got last=%0d count=%0d done=%0d fail=%b expected 33 33 34 0",
               lb, nb, dc, fail);
    end
  endtask

  task automatic test_fail_port_b();
    int fb, lb, nb, dc;
    inj_b = 1'b1; inj_b_addr = 4'd3;
    run(0, -1, fb, lb, nb, dc);
    checks++;
    if (dc !== 14 || lb !== 13) begin
      errors++;
      $display("FAIL fail_b_timing: got done=%0d last_busy=%0d expected 14 13", dc, lb);
    end
    checks++;
    if ({fail, fail_addr, fail_port, busy} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fail_b_report: got fail=%b addr=%0d port=%b busy=%b expected 1 3 1 0",
               fail, fail_addr, fail_port, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, fail, fail_addr, fail_port} !== {1'b1, 1'b1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL fail_b_hold: got done=%b fail=%b addr=%0d port=%b expected 1 1 3 1",
               done, fail, fail_addr, fail_port);
    end
    inj_b = 1'b0;
  endtask

  task automatic test_restart_clears();
    int cyc;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, fail, fail_addr, fail_port, busy} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL restart_clear: got done=%b fail=%b addr=%0d port=%b busy=%b expected 0 0 0 0 1",
               done, fail, fail_addr, fail_port, busy);
    end
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 34 || fail !== 1'b0) begin
      errors++;
      $display("FAIL restart_rerun: got done_cycle=%0d fail=%b expected 34 0", cyc, fail);
    end
  endtask

  task automatic test_both_ports();
    int fb, lb, nb, dc;
    inj_a = 1'b1; inj_b = 1'b1; inj_b_addr = 4'd10;
    run(0, -1, fb, lb, nb, dc);
    checks++;
    if ({fail, fail_addr, fail_port} !== {1'b1, 4'd2, 1'b0} || dc !== 29) begin
      errors++;
      $display("FAIL both_ports: got fail=%b addr=%0d port=%b done=%0d expected 1 2 0 29",
               fail, fail_addr, fail_port, dc);
    end
    inj_a = 1'b0; inj_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fb, lb, nb, dc;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({busy, we_a, we_b} !== 3'b111) begin
      errors++;
      $display("FAIL mid_fill_active: got busy/we_a/we_b=%b expected 111", {busy, we_a, we_b});
    end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_addr, fail_port, we_a, we_b, a_a, a_b, wd_a, wd_b} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {busy, done, fail, fail_addr, fail_port, we_a, we_b, a_a, a_b, wd_a, wd_b});
    end
    run(0, -1, fb, lb, nb, dc);
    checks++;
    if (nb !== 33 || dc !== 34 || fail !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_rerun: got count=%0d done=%0d fail=%b expected 33 34 0", nb, dc, fail);
    end
  endtask

  task automatic test_abits2();
    int fb, lb, nb, dc;
    run(1, -1, fb, lb, nb, dc);
    checks++;
    if (fb !== 1 || nb !== 9 || dc !== 10 || fail2 !== 1'b0) begin
      errors++;
      $display("FAIL abits2_run: got first=%0d count=%0d done=%0d fail=%b expected 1 9 10 0",
               fb, nb, dc, fail2);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_v;
      exp_v = (i < 2) ? ~d2(2'(i)) : d2(2'(i));
      checks++;
      if (mem2[i] !== exp_v) begin
        errors++;
        $display("FAIL abits2_mem[%0d]: got %h expected %h", i, mem2[i], exp_v);
      end
    end
  endtask

  task automatic test_no_collision();
    checks++;
    if (coll !== 0) begin
      errors++;
      $display("FAIL write_collision: got %0d colliding cycles expected 0", coll);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    test_reset();
    test_pass();
    test_start_ignored();
    test_fail_port_b();
    test_restart_clears();
    test_both_ports();
    test_reset_mid();
    test_abits2();
    test_no_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
